// File: rtl/ingress_wrreq_proc.sv
// Serialises posted memory-write TLPs from the ingress parse stage into
// per-DW writes on a local register/memory port, with packet and length-error stats.
module ingress_wrreq_proc #(
    parameter int DATA_W = 128,
    parameter int KEEP_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wrreq_data,
    input  logic [KEEP_W-1:0] wrreq_keep,
    input  logic [127:0]      wrreq_meta,
    input  logic              wrreq_valid,
    output logic              wrreq_rdy,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_be,
    input  logic              mem_wr_rdy,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              len_err,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic {
        S_IDLE,
        S_DATA
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [10:0]       r_rem;
    logic [3:0]        r_fbe;
    logic [3:0]        r_lbe;
    logic [1:0]        r_lane;
    logic              r_first;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_len_err;

    logic [2:0]        w_nv;
    logic              w_in_data;
    logic              w_wr_en;
    logic              w_accept;
    logic              w_last_dw;
    logic              w_lane_last;
    logic              w_beat_end;
    logic              w_overrun;
    logic              w_empty;
    logic [31:0]       w_lane_data;
    logic [3:0]        w_be;
    logic [63:0]       w_hdr_addr;
    logic [9:0]        w_hdr_len;
    logic [10:0]       w_hdr_rem;
    logic              w_unused;

    // Valid lanes are packed from lane 0, so the count stops at the first gap
    always_comb begin
        w_nv = '0;
        if (wrreq_keep[0]) begin
            w_nv = 3'd1;
            if (wrreq_keep[4]) begin
                w_nv = 3'd2;
                if (wrreq_keep[8]) begin
                    w_nv = 3'd3;
                    if (wrreq_keep[12]) w_nv = 3'd4;
                end
            end
        end
    end

    assign w_hdr_addr  = {wrreq_meta[95:64], wrreq_meta[127:96]};
    assign w_hdr_len   = wrreq_meta[9:0];
    assign w_hdr_rem   = (w_hdr_len == 10'd0) ? 11'd1024 : {1'b0, w_hdr_len};

    assign w_in_data   = (r_state == S_DATA) && wrreq_valid;
    assign w_wr_en     = w_in_data && ({1'b0, r_lane} < w_nv) && (r_rem != 11'd0);
    assign w_accept    = w_wr_en && mem_wr_rdy;
    assign w_last_dw   = (r_rem == 11'd1);
    assign w_lane_last = ({1'b0, r_lane} == (w_nv - 3'd1));
    assign w_beat_end  = w_accept && (w_lane_last || w_last_dw);
    // Length ran out with DWs still valid in the beat: the rest are discarded
    assign w_overrun   = w_accept && w_last_dw && !w_lane_last;
    assign w_empty     = w_in_data && (w_nv == 3'd0);

    assign w_lane_data = wrreq_data[{r_lane, 5'b00000} +: 32];
    assign w_be        = (w_last_dw && !r_first) ? r_lbe :
                         r_first                 ? r_fbe : 4'hF;

    assign wrreq_rdy   = w_beat_end || w_empty;
    assign mem_wr_en   = w_wr_en;
    assign mem_wr_addr = r_addr;
    assign mem_wr_data = w_wr_en ? w_lane_data : '0;
    assign mem_wr_be   = w_wr_en ? w_be : '0;
    assign pkt_cnt     = r_pkt_cnt;
    assign err_cnt     = r_err_cnt;
    assign len_err     = r_len_err;

    assign w_unused    = &{1'b0, wrreq_keep, wrreq_meta, w_hdr_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_fbe     <= '0;
            r_lbe     <= '0;
            r_lane    <= '0;
            r_first   <= 1'b0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_overrun || w_empty;
            if (w_overrun || w_empty) r_err_cnt <= r_err_cnt + CNT_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (wrreq_valid) begin
                        r_addr  <= w_hdr_addr[ADDR_W+1:2];
                        r_rem   <= w_hdr_rem;
                        r_fbe   <= wrreq_meta[35:32];
                        r_lbe   <= wrreq_meta[39:36];
                        r_lane  <= '0;
                        r_first <= 1'b1;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_rem   <= r_rem - 11'd1;
                        r_first <= 1'b0;
                        r_lane  <= w_beat_end ? 2'd0 : r_lane + 2'd1;
                        if (w_last_dw) begin
                            r_state   <= S_IDLE;
                            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ingress_wrreq_proc.sv
// Directed bench for ingress_wrreq_proc: write serialisation, byte enables,
// backpressure, length errors, back-to-back packets and mid-packet reset.
module tb_ingress_wrreq_proc;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] wrreq_data = '0;
    logic [15:0]  wrreq_keep = '0;
    logic [127:0] wrreq_meta = '0;
    logic         wrreq_valid = 1'b0;
    logic         wrreq_rdy;
    logic         mem_wr_en;
    logic [15:0]  mem_wr_addr;
    logic [31:0]  mem_wr_data;
    logic [3:0]   mem_wr_be;
    logic         mem_wr_rdy = 1'b1;
    logic [31:0]  pkt_cnt;
    logic         len_err;
    logic [31:0]  err_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ingress_wrreq_proc #(
        .DATA_W(128),
        .KEEP_W(16),
        .ADDR_W(16),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wrreq_data (wrreq_data),
        .wrreq_keep (wrreq_keep),
        .wrreq_meta (wrreq_meta),
        .wrreq_valid(wrreq_valid),
        .wrreq_rdy  (wrreq_rdy),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr_be  (mem_wr_be),
        .mem_wr_rdy (mem_wr_rdy),
        .pkt_cnt    (pkt_cnt),
        .len_err    (len_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed write log plus handshake statistics, sampled mid-cycle
    logic [15:0] m_addr [0:63];
    logic [31:0] m_data [0:63];
    logic [3:0]  m_be   [0:63];
    int          m_cyc  [0:63];
    int wcount = 0, pops = 0, lerrs = 0, lerr_cyc = 0, stall_viol = 0, stalls = 0;
    logic        p_stall = 1'b0;
    logic [15:0] p_a = '0;
    logic [31:0] p_d = '0;
    logic [3:0]  p_b = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (p_stall && (!mem_wr_en || mem_wr_addr !== p_a || mem_wr_data !== p_d || mem_wr_be !== p_b))
                stall_viol++;
            if (mem_wr_en && !mem_wr_rdy) begin
                stalls++;
                if (wrreq_rdy) stall_viol++;
            end
            if (mem_wr_en && mem_wr_rdy && wcount < 64) begin
                m_addr[wcount] = mem_wr_addr;
                m_data[wcount] = mem_wr_data;
                m_be[wcount]   = mem_wr_be;
                m_cyc[wcount]  = cyc;
                wcount++;
            end
            if (wrreq_valid && wrreq_rdy) pops++;
            if (len_err) begin
                lerrs++;
                lerr_cyc = cyc;
            end
        end
        p_stall = !rst && mem_wr_en && !mem_wr_rdy;
        p_a = mem_wr_addr;
        p_d = mem_wr_data;
        p_b = mem_wr_be;
    end

    logic [127:0] b_data [0:7];
    logic [15:0]  b_keep [0:7];
    logic [127:0] b_meta [0:7];

    function automatic logic [127:0] mk_meta(input logic [9:0] len, input logic [3:0] fbe,
                                             input logic [3:0] lbe, input logic [31:0] baddr);
        logic [127:0] m;
        m = '0;
        m[9:0]    = len;
        m[35:32]  = fbe;
        m[39:36]  = lbe;
        m[127:96] = baddr;
        return m;
    endfunction

    // Presents beats b_*[0..n-1] upstream-style, advancing on each pop
    task automatic run_beats(input int n, input bit tog, output int start_cyc);
        int idx = 0;
        int budget = 0;
        start_cyc = cyc;
        while (idx < n && budget < 400) begin
            wrreq_valid = 1'b1;
            wrreq_data  = b_data[idx];
            wrreq_keep  = b_keep[idx];
            wrreq_meta  = b_meta[idx];
            mem_wr_rdy  = tog ? ~mem_wr_rdy : 1'b1;
            @(negedge clk);
            if (wrreq_rdy) idx++;
            @(posedge clk);
            #1;
            budget++;
        end
        wrreq_valid = 1'b0;
        wrreq_data  = '0;
        wrreq_keep  = '0;
        mem_wr_rdy  = 1'b1;
        checks++;
        if (idx !== n) begin
            errors++;
            $display("FAIL beat_timeout popped=%0d required=%0d", idx, n);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({wrreq_rdy, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be, len_err} !== '0 ||
            pkt_cnt !== 32'd0 || err_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state rdy=%b en=%b addr=%h data=%h be=%h pkt=%0d err=%0d lerr=%b required all zero",
                     wrreq_rdy, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be, pkt_cnt, err_cnt, len_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_dw();
        int b, st;
        b = wcount;
        b_meta[0] = mk_meta(10'd1, 4'hF, 4'h0, 32'h100);
        b_keep[0] = 16'h000F;
        b_data[0] = {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hA5A5A5A5};
        run_beats(1, 1'b0, st);
        checks++;
        if (wcount - b !== 1) begin
            errors++;
            $display("FAIL single_count got=%0d required=1", wcount - b);
        end else begin
            checks++;
            if (m_addr[b] !== 16'h0040 || m_be[b] !== 4'hF || m_data[b] !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL single_write got addr=%h be=%h data=%h required 0040 F A5A5A5A5",
                         m_addr[b], m_be[b], m_data[b]);
            end
            checks++;
            if (m_cyc[b] !== st + 1) begin
                errors++;
                $display("FAIL single_latency got=%0d required=%0d", m_cyc[b] - st, 1);
            end
        end
        checks++;
        if (pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_pkt_cnt got=%0d required=1", pkt_cnt);
        end
    endtask

    task automatic test_multi_beat(input bit tog, input logic [31:0] exp_pkt);
        logic [31:0] exp_d [0:5];
        logic [3:0]  exp_b [0:5];
        int b, p, st;
        exp_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
        exp_b = '{4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hC};
        b = wcount;
        p = pops;
        b_meta[0] = mk_meta(10'd6, 4'h3, 4'hC, 32'h200);
        b_meta[1] = b_meta[0];
        b_keep[0] = 16'hFFFF;
        b_keep[1] = 16'h00FF;
        b_data[0] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        b_data[1] = {32'hDEADBEEF, 32'hDEADBEEF, 32'h66666666, 32'h55555555};
        run_beats(2, tog, st);
        checks++;
        if (wcount - b !== 6) begin
            errors++;
            $display("FAIL multi_count tog=%0d got=%0d required=6", tog, wcount - b);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (m_addr[b+i] !== 16'h0080 + 16'(i) || m_be[b+i] !== exp_b[i] || m_data[b+i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL multi_write tog=%0d idx=%0d got addr=%h be=%h data=%h required %h %h %h",
                             tog, i, m_addr[b+i], m_be[b+i], m_data[b+i], 16'h0080 + 16'(i), exp_b[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (pops - p !== 2) begin
            errors++;
            $display("FAIL multi_pops tog=%0d got=%0d required=2", tog, pops - p);
        end
        checks++;
        if (pkt_cnt !== exp_pkt) begin
            errors++;
            $display("FAIL multi_pkt_cnt tog=%0d got=%0d required=%0d", tog, pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        s0 = stalls;
        test_multi_beat(1'b1, 32'd3);
        checks++;
        if (stalls - s0 < 1) begin
            errors++;
            $display("FAIL bp_stalls got=%0d required>=1", stalls - s0);
        end
        checks++;
        if (stall_viol !== 0) begin
            errors++;
            $display("FAIL bp_stable got=%0d violations required=0", stall_viol);
        end
    endtask

    task automatic test_overrun();
        int b, p, l, st;
        b = wcount;
        p = pops;
        l = lerrs;
        b_meta[0] = mk_meta(10'd2, 4'hF, 4'h7, 32'h300);
        b_keep[0] = 16'hFFFF;
        b_data[0] = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
        run_beats(1, 1'b0, st);
        checks++;
        if (wcount - b !== 2) begin
            errors++;
            $display("FAIL ovr_count got=%0d required=2", wcount - b);
        end else begin
            checks++;
            if (m_addr[b] !== 16'h00C0 || m_be[b] !== 4'hF || m_data[b] !== 32'hC0C0C0C0 ||
                m_addr[b+1] !== 16'h00C1 || m_be[b+1] !== 4'h7 || m_data[b+1] !== 32'hC1C1C1C1) begin
                errors++;
                $display("FAIL ovr_writes got %h/%h/%h %h/%h/%h required 00C0/F/C0C0C0C0 00C1/7/C1C1C1C1",
                         m_addr[b], m_be[b], m_data[b], m_addr[b+1], m_be[b+1], m_data[b+1]);
            end
            checks++;
            if (lerrs - l !== 1 || lerr_cyc !== m_cyc[b+1] + 1) begin
                errors++;
                $display("FAIL ovr_len_err got pulses=%0d at=%0d required 1 at %0d",
                         lerrs - l, lerr_cyc, m_cyc[b+1] + 1);
            end
        end
        checks++;
        if (pops - p !== 1 || err_cnt !== 32'd1 || pkt_cnt !== 32'd4) begin
            errors++;
            $display("FAIL ovr_stats got pops=%0d err=%0d pkt=%0d required 1 1 4", pops - p, err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_empty_beat();
        int b, p, l, st;
        b = wcount;
        p = pops;
        l = lerrs;
        b_meta[0] = mk_meta(10'd2, 4'h1, 4'h8, 32'h400);
        b_meta[1] = b_meta[0];
        b_keep[0] = 16'h0000;
        b_keep[1] = 16'h00FF;
        b_data[0] = {4{32'hBADBAD00}};
        b_data[1] = {32'h0, 32'h0, 32'hE2E2E2E2, 32'hE1E1E1E1};
        run_beats(2, 1'b0, st);
        checks++;
        if (wcount - b !== 2) begin
            errors++;
            $display("FAIL empty_count got=%0d required=2", wcount - b);
        end else begin
            checks++;
            if (m_addr[b] !== 16'h0100 || m_be[b] !== 4'h1 || m_data[b] !== 32'hE1E1E1E1 ||
                m_addr[b+1] !== 16'h0101 || m_be[b+1] !== 4'h8 || m_data[b+1] !== 32'hE2E2E2E2) begin
                errors++;
                $display("FAIL empty_writes got %h/%h/%h %h/%h/%h required 0100/1/E1E1E1E1 0101/8/E2E2E2E2",
                         m_addr[b], m_be[b], m_data[b], m_addr[b+1], m_be[b+1], m_data[b+1]);
            end
        end
        checks++;
        if (pops - p !== 2 || lerrs - l !== 1 || err_cnt !== 32'd2 || pkt_cnt !== 32'd5) begin
            errors++;
            $display("FAIL empty_stats got pops=%0d lerr=%0d err=%0d pkt=%0d required 2 1 2 5",
                     pops - p, lerrs - l, err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int b, l, st;
        b = wcount;
        l = lerrs;
        b_meta[0] = mk_meta(10'd4, 4'hF, 4'hF, 32'h500);
        b_meta[1] = mk_meta(10'd4, 4'hF, 4'hF, 32'h600);
        b_keep[0] = 16'hFFFF;
        b_keep[1] = 16'hFFFF;
        b_data[0] = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        b_data[1] = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
        run_beats(2, 1'b0, st);
        checks++;
        if (wcount - b !== 8) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=8", wcount - b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (m_addr[b+i] !== ((i < 4) ? 16'h0140 + 16'(i) : 16'h0180 + 16'(i - 4)) ||
                    m_data[b+i] !== ((i < 4) ? 32'hA0000000 + 32'(i) : 32'hB0000000 + 32'(i - 4))) begin
                    errors++;
                    $display("FAIL b2b_write idx=%0d got addr=%h data=%h", i, m_addr[b+i], m_data[b+i]);
                end
            end
            checks++;
            if (m_cyc[b] !== st + 1 || m_cyc[b+3] !== st + 4 || m_cyc[b+4] !== st + 6 || m_cyc[b+7] !== st + 9) begin
                errors++;
                $display("FAIL b2b_timing got offsets %0d %0d %0d %0d required 1 4 6 9",
                         m_cyc[b] - st, m_cyc[b+3] - st, m_cyc[b+4] - st, m_cyc[b+7] - st);
            end
        end
        checks++;
        if (pkt_cnt !== 32'd7 || lerrs - l !== 0) begin
            errors++;
            $display("FAIL b2b_stats got pkt=%0d lerr=%0d required 7 0", pkt_cnt, lerrs - l);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        int budget = 0;
        int b, st;
        wrreq_meta  = mk_meta(10'd8, 4'hF, 4'hF, 32'h700);
        wrreq_keep  = 16'hFFFF;
        wrreq_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        wrreq_valid = 1'b1;
        mem_wr_rdy  = 1'b1;
        while (n < 3 && budget < 50) begin
            @(negedge clk);
            if (mem_wr_en && mem_wr_rdy) n++;
            @(posedge clk);
            #1;
            budget++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL rst_pre_writes got=%0d required=3", n);
        end
        rst = 1'b1;
        wrreq_valid = 1'b0;
        wrreq_data  = '0;
        wrreq_keep  = '0;
        wrreq_meta  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wrreq_rdy, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be, len_err} !== '0 ||
            pkt_cnt !== 32'd0 || err_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_clear rdy=%b en=%b addr=%h data=%h be=%h pkt=%0d err=%0d lerr=%b required all zero",
                     wrreq_rdy, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be, pkt_cnt, err_cnt, len_err);
        end
        @(posedge clk);
        #1;
        b = wcount;
        b_meta[0] = mk_meta(10'd1, 4'hF, 4'h0, 32'h10);
        b_keep[0] = 16'h000F;
        b_data[0] = {96'h0, 32'h12345678};
        run_beats(1, 1'b0, st);
        checks++;
        if (wcount - b !== 1 || m_addr[b] !== 16'h0004 || m_data[b] !== 32'h12345678 || m_be[b] !== 4'hF) begin
            errors++;
            $display("FAIL rst_next_pkt got count=%0d addr=%h data=%h be=%h required 1 0004 12345678 F",
                     wcount - b, m_addr[b], m_data[b], m_be[b]);
        end
        checks++;
        if (pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rst_pkt_cnt got=%0d required=1", pkt_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single_dw();
        test_multi_beat(1'b0, 32'd2);
        test_backpressure();
        test_overrun();
        test_empty_beat();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
